// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one synchronous data-memory port between NREQ requesters (for
//   example the pipeline M stage and an IO/DMA engine). One request is
//   granted per cycle by a round-robin scheduler. A requester may lock the
//   port for a burst of at most MAX_BURST grants. Read data coming back one
//   cycle later is steered to the requester that issued the read.
//
// Ports
//   clock          rising-edge clock
//   reset          asynchronous reset, active low (asserted at 0)
//   req_valid      per-requester request pending
//   req_lock       per-requester "keep ownership after this grant"
//   req_we         per-requester 1=write, 0=read
//   req_addr       packed word addresses, requester i at [i*AW +: AW]
//   req_wdata      packed write data, requester i at [i*DW +: DW]
//   req_type       packed funct3 read types, requester i at [i*3 +: 3]
//   req_ready      one-hot grant, request accepted this cycle
//   rsp_valid      one-hot, read data valid for requester i
//   rsp_data       read data (0 when no response)
//   mem_addr       address to dmem
//   mem_wdata      write data to dmem
//   mem_we         write enable to dmem
//   mem_read_type  funct3 read type to dmem
//   mem_rdata      dmem read data, valid one cycle after the address
module dmem_arbiter #(
  parameter int NREQ      = 2,
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int MAX_BURST = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ-1:0]   req_lock,
  input  logic [NREQ-1:0]   req_we,
  input  logic [NREQ*AW-1:0] req_addr,
  input  logic [NREQ*DW-1:0] req_wdata,
  input  logic [NREQ*3-1:0] req_type,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [DW-1:0]     rsp_data,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  output logic              mem_we,
  output logic [2:0]        mem_read_type,
  input  logic [DW-1:0]     mem_rdata
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {
    ARB,
    LOCK
  } state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [BW-1:0]   burst_cnt;
  logic            rsp_pend;
  logic [PW-1:0]   rsp_id;

  logic            owner_hold;
  logic [PW-1:0]   scan_start;
  logic            grant_any;
  logic [PW-1:0]   grant_idx;
  logic            grant_read;
  int              scan_idx;

  // Index of the requester after i, wrapping NREQ-1 back to 0.
  function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] i);
    if (int'(i) == NREQ - 1) begin
      return '0;
    end
    return i + PW'(1);
  endfunction

  // Grant selection. A locked owner that still has burst budget and a
  // pending request keeps the port. Otherwise (plain arbitration or a
  // forced release) the first valid requester from the scan start wins;
  // on a release the scan starts just past the old owner, so the old
  // owner is only picked when nobody else is waiting. Reset masks every
  // grant so nothing reaches the memory while reset is held.
  always_comb begin
    owner_hold = (state == LOCK) && req_valid[owner] &&
                 (burst_cnt < BW'(MAX_BURST));
    scan_start = (state == LOCK) ? next_idx(owner) : ptr;
    grant_any  = 1'b0;
    grant_idx  = '0;
    scan_idx   = 0;
    if (owner_hold) begin
      grant_any = 1'b1;
      grant_idx = owner;
    end else begin
      for (int k = 0; k < NREQ; k++) begin
        scan_idx = (int'(scan_start) + k) % NREQ;
        if (!grant_any && req_valid[scan_idx]) begin
          grant_any = 1'b1;
          grant_idx = PW'(scan_idx);
        end
      end
    end
    if (!reset) begin
      grant_any = 1'b0;
    end
    grant_read = grant_any && !req_we[grant_idx];
  end

  // Memory drive and one-hot ready come straight from the granted slice;
  // an idle cycle drives all zeros so the RAM sees no stray write.
  always_comb begin
    req_ready     = '0;
    mem_addr      = '0;
    mem_wdata     = '0;
    mem_we        = 1'b0;
    mem_read_type = 3'b000;
    if (grant_any) begin
      req_ready[grant_idx] = 1'b1;
      mem_addr             = req_addr[int'(grant_idx)*AW +: AW];
      mem_wdata            = req_wdata[int'(grant_idx)*DW +: DW];
      mem_we               = req_we[grant_idx];
      mem_read_type        = req_type[int'(grant_idx)*3 +: 3];
    end
  end

  // Read responses: the RAM returns data one cycle after the address, so
  // the registered requester id simply steers the passthrough data.
  always_comb begin
    rsp_valid = '0;
    rsp_data  = '0;
    if (rsp_pend && reset) begin
      rsp_valid[rsp_id] = 1'b1;
      rsp_data          = mem_rdata;
    end
  end

  // Arbiter state. While a lock is held the round-robin pointer is frozen
  // (it already points past the owner from the grant that opened the
  // lock). Releasing, whether voluntary or forced, leaves the pointer just
  // past the owner unless a new grant moves it on.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= ARB;
      ptr       <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      rsp_pend  <= 1'b0;
      rsp_id    <= '0;
    end else begin
      rsp_pend <= grant_read;
      if (grant_read) begin
        rsp_id <= grant_idx;
      end
      if (owner_hold) begin
        burst_cnt <= burst_cnt + BW'(1);
        if (!req_lock[owner]) begin
          state <= ARB;
          ptr   <= next_idx(owner);
        end
      end else if (grant_any) begin
        ptr <= next_idx(grant_idx);
        if (req_lock[grant_idx] && (MAX_BURST > 1)) begin
          state     <= LOCK;
          owner     <= grant_idx;
          burst_cnt <= BW'(1);
        end else begin
          state <= ARB;
        end
      end else if (state == LOCK) begin
        state <= ARB;
        ptr   <= next_idx(owner);
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter
//   Self-checking bench for dmem_arbiter with NREQ=2, MAX_BURST=4. A small
//   synchronous RAM sits on the mem_* port. Test tasks drive requests,
//   check grants and memory drive inline, and push expected read responses
//   into a scoreboard that a negedge monitor pops and compares.
module tb_dmem_arbiter;

  localparam int NREQ      = 2;
  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int MAX_BURST = 4;

  logic                clock = 1'b0;
  logic                reset = 1'b0;
  logic [NREQ-1:0]     req_valid = '0;
  logic [NREQ-1:0]     req_lock = '0;
  logic [NREQ-1:0]     req_we = '0;
  logic [NREQ*AW-1:0]  req_addr = '0;
  logic [NREQ*DW-1:0]  req_wdata = '0;
  logic [NREQ*3-1:0]   req_type = '0;
  logic [NREQ-1:0]     req_ready;
  logic [NREQ-1:0]     rsp_valid;
  logic [DW-1:0]       rsp_data;
  logic [AW-1:0]       mem_addr;
  logic [DW-1:0]       mem_wdata;
  logic                mem_we;
  logic [2:0]          mem_read_type;
  logic [DW-1:0]       mem_rdata = '0;

  logic [31:0] ram [0:4095];
  logic [31:0] model_mem [0:4095];

  int checks = 0;
  int errors = 0;
  int pcyc = 0;

  typedef struct {
    int          due;
    logic [1:0]  id;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  rsp_t mon_e;

  dmem_arbiter #(
    .NREQ(NREQ), .AW(AW), .DW(DW), .MAX_BURST(MAX_BURST)
  ) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_lock(req_lock), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_type(req_type),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_read_type(mem_read_type), .mem_rdata(mem_rdata)
  );

  // Free-running clock, 10 time units per cycle.
  always #5 clock = ~clock;

  // Synchronous RAM on the arbiter's memory port: read data appears one
  // cycle after the address.
  always @(posedge clock) begin
    if (mem_we) ram[mem_addr[11:0]] <= mem_wdata;
    mem_rdata <= ram[mem_addr[11:0]];
  end

  // Cycle counter used to time-stamp expected responses.
  always @(posedge clock) pcyc <= pcyc + 1;

  // Response monitor: in each cycle either the oldest expected response is
  // due and must match, or the response port must be idle.
  always @(negedge clock) begin
    if (sb.size() > 0 && sb[0].due == pcyc) begin
      mon_e = sb.pop_front();
      checks++;
      if (rsp_valid !== mon_e.id || rsp_data !== mon_e.data) begin
        errors++;
        $display("[TB] FAIL rsp cyc=%0d: got valid=%b data=%h, expected valid=%b data=%h",
                 pcyc, rsp_valid, rsp_data, mon_e.id, mon_e.data);
      end
    end else begin
      checks++;
      if (rsp_valid !== 2'b00 || rsp_data !== 32'h0) begin
        errors++;
        $display("[TB] FAIL rsp_idle cyc=%0d: got valid=%b data=%h, expected valid=00 data=0",
                 pcyc, rsp_valid, rsp_data);
      end
    end
  end

  task automatic set_req(input int i, input logic v, input logic lk, input logic we,
                         input logic [31:0] a, input logic [31:0] d, input logic [2:0] t);
    req_valid[i]           = v;
    req_lock[i]            = lk;
    req_we[i]              = we;
    req_addr[i*AW +: AW]   = a;
    req_wdata[i*DW +: DW]  = d;
    req_type[i*3 +: 3]     = t;
  endtask

  task automatic clear_reqs();
    req_valid = '0;
    req_lock  = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    req_type  = '0;
  endtask

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic push_rsp(input logic [1:0] id, input logic [11:0] a);
    rsp_t e;
    e.due  = pcyc + 1;
    e.id   = id;
    e.data = model_mem[a];
    sb.push_back(e);
  endtask

  // Reset holds everything quiet even with a pending request; after
  // release with no requests the memory port stays at zero.
  task automatic test_reset();
    reset = 1'b0;
    clear_reqs();
    repeat (2) next_cycle();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 3'b010);
    #2;
    checks++;
    if (req_ready !== 2'b00 || mem_we !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_hold: got ready=%b we=%b addr=%h, expected 00 0 0",
               req_ready, mem_we, mem_addr);
    end
    next_cycle();
    clear_reqs();
    reset = 1'b1;
    repeat (3) begin
      next_cycle();
      #2;
      checks++;
      if (req_ready !== 2'b00 || mem_addr !== 32'h0 || mem_we !== 1'b0 ||
          mem_wdata !== 32'h0 || mem_read_type !== 3'b000) begin
        errors++;
        $display("[TB] FAIL idle_mem: got ready=%b addr=%h we=%b wdata=%h type=%b, expected all zero",
                 req_ready, mem_addr, mem_we, mem_wdata, mem_read_type);
      end
    end
  endtask

  // Both requesters read continuously: grants alternate starting at 0.
  task automatic test_round_robin();
    logic [1:0]  exp_g;
    logic [11:0] exp_a;
    logic [2:0]  exp_t;
    next_cycle();
    set_req(0, 1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 3'b010);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 3'b100);
    for (int k = 0; k < 4; k++) begin
      exp_g = (k % 2 == 1) ? 2'b10 : 2'b01;
      exp_a = (k % 2 == 1) ? 12'h020 : 12'h010;
      exp_t = (k % 2 == 1) ? 3'b100 : 3'b010;
      #2;
      checks++;
      if (req_ready !== exp_g || mem_addr !== {20'h0, exp_a} ||
          mem_we !== 1'b0 || mem_read_type !== exp_t) begin
        errors++;
        $display("[TB] FAIL rr_grant k=%0d: got ready=%b addr=%h we=%b type=%b, expected %b %h 0 %b",
                 k, req_ready, mem_addr, mem_we, mem_read_type, exp_g, exp_a, exp_t);
      end
      push_rsp(exp_g, exp_a);
      next_cycle();
    end
    clear_reqs();
    next_cycle();
  endtask

  // A write reaches the RAM in its grant cycle, gives no response, and a
  // later read returns the written word.
  task automatic test_write();
    set_req(0, 1'b1, 1'b0, 1'b1, 32'h7F0, 32'hDEADBEEF, 3'b000);
    #2;
    checks++;
    if (req_ready !== 2'b01 || mem_we !== 1'b1 || mem_addr !== 32'h7F0 ||
        mem_wdata !== 32'hDEADBEEF) begin
      errors++;
      $display("[TB] FAIL write_drive: got ready=%b we=%b addr=%h wdata=%h, expected 01 1 7f0 deadbeef",
               req_ready, mem_we, mem_addr, mem_wdata);
    end
    model_mem[12'h7F0] = 32'hDEADBEEF;
    next_cycle();
    clear_reqs();
    #2;
    checks++;
    if (req_ready !== 2'b00 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL write_after: got ready=%b we=%b, expected 00 0", req_ready, mem_we);
    end
    next_cycle();
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h7F0, 32'h0, 3'b010);
    #2;
    checks++;
    if (req_ready !== 2'b10 || mem_we !== 1'b0 || mem_addr !== 32'h7F0) begin
      errors++;
      $display("[TB] FAIL write_readback_grant: got ready=%b we=%b addr=%h, expected 10 0 7f0",
               req_ready, mem_we, mem_addr);
    end
    push_rsp(2'b10, 12'h7F0);
    next_cycle();
    clear_reqs();
    next_cycle();
  endtask

  // Requester 0 holds lock continuously: it gets MAX_BURST grants, then
  // requester 1 is forced in, then requester 0 relocks.
  task automatic test_lock_cap();
    logic [1:0] exp_seq [6];
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b10, 2'b01};
    set_req(0, 1'b1, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010);
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 3'b010);
    for (int k = 0; k < 6; k++) begin
      #2;
      checks++;
      if (req_ready !== exp_seq[k]) begin
        errors++;
        $display("[TB] FAIL lock_cap k=%0d: got ready=%b, expected %b", k, req_ready, exp_seq[k]);
      end
      push_rsp(exp_seq[k], (exp_seq[k] == 2'b10) ? 12'h020 : 12'h010);
      next_cycle();
    end
    clear_reqs();
    repeat (2) next_cycle();
  endtask

  // Lock held for two grants, dropped on the third: the owner gets three
  // grants even with requester 1 waiting, then requester 1 is served.
  task automatic test_lock_early();
    logic [1:0]  exp_seq [4];
    logic [11:0] exp_a;
    exp_seq = '{2'b01, 2'b01, 2'b01, 2'b10};
    for (int k = 0; k < 4; k++) begin
      if (k == 0) set_req(0, 1'b1, 1'b1, 1'b0, 32'h30, 32'h0, 3'b010);
      if (k == 1) set_req(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, 3'b010);
      if (k == 2) set_req(0, 1'b1, 1'b0, 1'b0, 32'h30, 32'h0, 3'b010);
      exp_a = (exp_seq[k] == 2'b10) ? 12'h040 : 12'h030;
      #2;
      checks++;
      if (req_ready !== exp_seq[k] || mem_addr !== {20'h0, exp_a}) begin
        errors++;
        $display("[TB] FAIL lock_early k=%0d: got ready=%b addr=%h, expected %b %h",
                 k, req_ready, mem_addr, exp_seq[k], exp_a);
      end
      push_rsp(exp_seq[k], exp_a);
      next_cycle();
    end
    clear_reqs();
    next_cycle();
  endtask

  // A read accepted just before reset must never produce a response;
  // the next read after release has normal one-cycle latency.
  task automatic test_reset_mid_read();
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h20, 32'h0, 3'b010);
    #2;
    checks++;
    if (req_ready !== 2'b10) begin
      errors++;
      $display("[TB] FAIL midread_grant: got ready=%b, expected 10", req_ready);
    end
    @(posedge clock);
    #1;
    reset = 1'b0;
    clear_reqs();
    #1;
    checks++;
    if (rsp_valid !== 2'b00 || req_ready !== 2'b00 || mem_we !== 1'b0) begin
      errors++;
      $display("[TB] FAIL midread_async: got rsp_valid=%b ready=%b we=%b, expected 00 00 0",
               rsp_valid, req_ready, mem_we);
    end
    repeat (2) next_cycle();
    reset = 1'b1;
    next_cycle();
    set_req(1, 1'b1, 1'b0, 1'b0, 32'h50, 32'h0, 3'b010);
    #2;
    checks++;
    if (req_ready !== 2'b10 || mem_addr !== 32'h50) begin
      errors++;
      $display("[TB] FAIL midread_next_grant: got ready=%b addr=%h, expected 10 50",
               req_ready, mem_addr);
    end
    push_rsp(2'b10, 12'h050);
    next_cycle();
    clear_reqs();
    repeat (2) next_cycle();
  endtask

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "[TB] timeout");
  end

  // Main sequence: preload memory, run every scenario, then summarize.
  initial begin
    for (int a = 0; a < 4096; a++) begin
      ram[a]       = {20'hC0FFE, a[11:0]};
      model_mem[a] = {20'hC0FFE, a[11:0]};
    end
    test_reset();
    test_round_robin();
    test_write();
    test_lock_cap();
    test_lock_early();
    test_reset_mid_read();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL sb_drain: got %0d pending responses, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
